// File: rtl/ahb_pkg.sv
//------------------------------------------------------------------------------
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite encodings (htrans, hsize, hresp), the slave FSM
//            state type and a byte-lane enable helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

   // htrans encodings
   localparam logic [1:0] c_htrans_idle   = 2'd0;
   localparam logic [1:0] c_htrans_busy   = 2'd1;
   localparam logic [1:0] c_htrans_nonseq = 2'd2;
   localparam logic [1:0] c_htrans_seq    = 2'd3;

   // hsize encodings (larger sizes are rejected with ERROR)
   localparam logic [2:0] c_hsize_byte = 3'd0;
   localparam logic [2:0] c_hsize_half = 3'd1;
   localparam logic [2:0] c_hsize_word = 3'd2;

   // hresp encodings
   localparam logic c_hresp_okay  = 1'b0;
   localparam logic c_hresp_error = 1'b1;

   // Slave FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } ahb_state_t;

   // Little-endian byte-lane enables for an aligned transfer.
   function automatic logic [3:0] ahb_byte_en(input logic [2:0] size,
                                              input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         c_hsize_byte: be = 4'b0001 << lane;
         c_hsize_half: be = lane[1] ? 4'b1100 : 4'b0011;
         default:      be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slave_mem_if.sv
//------------------------------------------------------------------------------
// Module   : ahb_slave_mem_if
// Purpose  : AHB-Lite slave-side bus bundle.
// Ports    : master modport drives hsel/haddr/hwrite/hsize/hburst/htrans/
//            hready/hwdata and observes hreadyout/hresp/hrdata; the slave
//            modport is the mirror image.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_slave_mem_if;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic        hready;
   logic [31:0] hwdata;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport slave (
      input  hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
      output hreadyout, hresp, hrdata
   );

   modport master (
      output hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
      input  hreadyout, hresp, hrdata
   );
endinterface

`default_nettype wire

// File: rtl/ahb_sram_be.sv
//------------------------------------------------------------------------------
// Module   : ahb_sram_be
// Purpose  : MEM_WORDS x 32-bit storage with per-byte write enables and a
//            registered (synchronous) read port. Contents are not reset.
// Ports    : hclk          clock
//            we/be/waddr/wdata  write port, byte lanes gated by be
//            re/raddr/rdata     read port, rdata updates on edges with re = 1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_sram_be #(
   parameter int MEM_WORDS = 256
) (
   input  wire logic                         hclk,
   input  wire logic                         we,
   input  wire logic [3:0]                   be,
   input  wire logic [$clog2(MEM_WORDS)-1:0] waddr,
   input  wire logic [31:0]                  wdata,
   input  wire logic                         re,
   input  wire logic [$clog2(MEM_WORDS)-1:0] raddr,
   output wire       [31:0]                  rdata
);

   // One byte-wide array per lane keeps each lane a plain single-port write.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] r_mem [MEM_WORDS];
      logic [7:0] r_q;

      always_ff @(posedge hclk) begin
         if (we && be[i]) begin
            r_mem[waddr] <= wdata[8*i +: 8];
         end
         if (re) begin
            r_q <= r_mem[raddr];
         end
      end

      assign rdata[8*i +: 8] = r_q;
   end

endmodule

`default_nettype wire

// File: rtl/ahb_slave_mem.sv
//------------------------------------------------------------------------------
// Module   : ahb_slave_mem
// Purpose  : AHB-Lite memory slave with programmable wait states, ERROR
//            response for bad size/alignment/range, byte-lane writes and a
//            read-after-write bypass for pipelined back-to-back transfers.
// Ports    : hclk     clock (rising edge)
//            hresetn  asynchronous active-low reset
//            bus      ahb_slave_mem_if.slave (address/data phase signals)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_CYCLES = 1
) (
   input wire logic      hclk,
   input wire logic      hresetn,
   ahb_slave_mem_if.slave bus
);

   localparam int         c_aw        = $clog2(MEM_WORDS);
   localparam logic [2:0] c_wait_load = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   ahb_state_t        r_state;
   logic [2:0]        r_cnt;
   logic              r_hreadyout;
   logic              r_hresp;
   logic [31:0]       r_hrdata;
   logic              r_pend;        // a valid data phase completes this cycle
   logic              r_write;
   logic [2:0]        r_size;
   logic [c_aw+1:0]   r_addr;
   logic              r_byp;
   logic [3:0]        r_byp_be;
   logic [31:0]       r_byp_data;

   logic              w_accept;
   logic              w_err;
   logic              w_commit;
   logic [3:0]        w_be;
   logic              w_re;
   logic [c_aw-1:0]   w_raddr;
   logic [31:0]       w_sram_q;
   logic [31:0]       w_rd_word;
   logic [31:0]       w_hrdata;
   logic              w_unused_bits;

   // Only sample a new address phase while our own data phase is not stalled.
   assign w_accept = bus.hsel & bus.hready & bus.htrans[1] & r_hreadyout;

   assign w_err = (bus.hsize > c_hsize_word)
                | ((bus.hsize == c_hsize_half) & bus.haddr[0])
                | ((bus.hsize == c_hsize_word) & (|bus.haddr[1:0]))
                | ({2'b00, bus.haddr[31:2]} >= 32'(MEM_WORDS));

   assign w_commit = r_pend & r_write;
   assign w_be     = ahb_byte_en(r_size, r_addr[1:0]);

   // The array is read on the edge that enters the completing cycle: the
   // last WAIT edge (captured address) or, with zero wait states, the
   // acceptance edge itself (live address).
   assign w_re    = ((r_state == ST_WAIT) && (r_cnt == 3'd0) && !r_write)
                  || ((WAIT_CYCLES == 0) && w_accept && !w_err && !bus.hwrite);
   assign w_raddr = (r_state == ST_WAIT) ? r_addr[c_aw+1:2] : bus.haddr[c_aw+1:2];

   ahb_sram_be #(
      .MEM_WORDS (MEM_WORDS)
   ) u_sram (
      .hclk  (hclk),
      .we    (w_commit),
      .be    (w_be),
      .waddr (r_addr[c_aw+1:2]),
      .wdata (bus.hwdata),
      .re    (w_re),
      .raddr (w_raddr),
      .rdata (w_sram_q)
   );

   // A write that committed on the same edge as the array read is not yet
   // visible in w_sram_q; merge its enabled lanes in.
   always_comb begin
      w_rd_word = w_sram_q;
      for (int i = 0; i < 4; i++) begin
         if (r_byp && r_byp_be[i]) begin
            w_rd_word[8*i +: 8] = r_byp_data[8*i +: 8];
         end
      end
   end

   assign w_hrdata = (r_pend && !r_write) ? w_rd_word : r_hrdata;

   assign bus.hreadyout = r_hreadyout;
   assign bus.hresp     = r_hresp;
   assign bus.hrdata    = w_hrdata;

   assign w_unused_bits = ^{bus.hburst, bus.htrans[0]};

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= c_hresp_okay;
         r_hrdata    <= 32'd0;
         r_pend      <= 1'b0;
         r_write     <= 1'b0;
         r_size      <= 3'd0;
         r_addr      <= '0;
         r_byp       <= 1'b0;
         r_byp_be    <= 4'd0;
         r_byp_data  <= 32'd0;
      end else begin
         r_hrdata <= w_hrdata;
         r_byp    <= w_re && w_commit && (w_raddr == r_addr[c_aw+1:2]);
         if (w_commit) begin
            r_byp_be   <= w_be;
            r_byp_data <= bus.hwdata;
         end
         r_pend <= 1'b0;

         case (r_state)
            ST_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state     <= ST_IDLE;
                  r_pend      <= 1'b1;
                  r_hreadyout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_hresp_error;
            end
            default: begin  // ST_IDLE, ST_ERR2: hreadyout = 1, may accept
               r_state     <= ST_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_hresp_okay;
               if (w_accept) begin
                  r_write <= bus.hwrite;
                  r_size  <= bus.hsize;
                  r_addr  <= bus.haddr[c_aw+1:0];
                  if (w_err) begin
                     r_state     <= ST_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= c_hresp_error;
                  end else if (WAIT_CYCLES == 0) begin
                     r_pend <= 1'b1;
                  end else begin
                     r_state     <= ST_WAIT;
                     r_cnt       <= c_wait_load;
                     r_hreadyout <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
//------------------------------------------------------------------------------
// Module   : tb_ahb_slave_mem
// Purpose  : Self-checking bench for ahb_slave_mem. Three instances share one
//            master bus (selected by hsel) with WAIT_CYCLES = 1, 0 and 3.
//            Expected values come from a byte-addressed memory model.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_slave_mem;
   import ahb_pkg::*;

   logic        hclk = 1'b0;
   logic [2:0]  rstn;
   logic [2:0]  hsel_v;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic        hready;
   logic [31:0] hwdata;

   wire  [2:0]  w_ro;
   wire  [2:0]  w_rs;
   wire  [31:0] w_rd [3];

   int          n_total = 0;
   int          n_pass  = 0;
   int          c_wait [3] = '{1, 0, 3};

   logic [7:0]  mdl   [3][1024];
   bit          known [3][1024];

   always #5 hclk = ~hclk;

   ahb_slave_mem_if bus0 ();
   ahb_slave_mem_if bus1 ();
   ahb_slave_mem_if bus2 ();

   ahb_slave_mem #(.MEM_WORDS(256), .WAIT_CYCLES(1)) u_dut_w1 (
      .hclk(hclk), .hresetn(rstn[0]), .bus(bus0));
   ahb_slave_mem #(.MEM_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
      .hclk(hclk), .hresetn(rstn[1]), .bus(bus1));
   ahb_slave_mem #(.MEM_WORDS(256), .WAIT_CYCLES(3)) u_dut_w3 (
      .hclk(hclk), .hresetn(rstn[2]), .bus(bus2));

   assign bus0.hsel = hsel_v[0]; assign bus1.hsel = hsel_v[1]; assign bus2.hsel = hsel_v[2];
   assign bus0.haddr = haddr;    assign bus1.haddr = haddr;    assign bus2.haddr = haddr;
   assign bus0.hwrite = hwrite;  assign bus1.hwrite = hwrite;  assign bus2.hwrite = hwrite;
   assign bus0.hsize = hsize;    assign bus1.hsize = hsize;    assign bus2.hsize = hsize;
   assign bus0.hburst = hburst;  assign bus1.hburst = hburst;  assign bus2.hburst = hburst;
   assign bus0.htrans = htrans;  assign bus1.htrans = htrans;  assign bus2.htrans = htrans;
   assign bus0.hready = hready;  assign bus1.hready = hready;  assign bus2.hready = hready;
   assign bus0.hwdata = hwdata;  assign bus1.hwdata = hwdata;  assign bus2.hwdata = hwdata;

   assign w_ro = {bus2.hreadyout, bus1.hreadyout, bus0.hreadyout};
   assign w_rs = {bus2.hresp, bus1.hresp, bus0.hresp};
   assign w_rd[0] = bus0.hrdata;
   assign w_rd[1] = bus1.hrdata;
   assign w_rd[2] = bus2.hrdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One transfer: address phase now (at a falling edge), returns at the
   // falling edge inside the completing cycle, leaving hwdata on the bus.
   task automatic xfer(input int d, input logic [1:0] tr, input bit wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int waits, output int errs);
      int cyc;
      hsel_v = 3'b000; hsel_v[d] = 1'b1;
      htrans = tr; haddr = addr; hwrite = wr; hsize = size; hready = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
      hsel_v = 3'b000; htrans = c_htrans_idle; hwdata = wd;
      waits = 0; errs = 0; cyc = 0;
      while (w_ro[d] !== 1'b1 && cyc < 20) begin
         if (w_rs[d] === 1'b1) errs++;
         waits++; cyc++;
         @(negedge hclk);
      end
      if (cyc >= 20) chk("timeout_hreadyout", {31'd0, w_ro[d]}, 32'd1);
      if (w_rs[d] === 1'b1) errs++;
      rd = w_rd[d];
   endtask

   // Transfer plus model update / comparison.
   task automatic op(input int d, input logic [1:0] tr, input bit wr,
                     input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wd, input string tag,
                     output logic [31:0] rd);
      bit          exp_err, all_known;
      int          waits, errs;
      logic [31:0] exp, a;
      exp_err = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
                (size == 3'd2 && addr[1:0] != 2'b00) || (addr >= 32'd1024);
      xfer(d, tr, wr, addr, size, wd, rd, waits, errs);
      if (exp_err) begin
         chk({tag, "/err_resp_cycles"}, 32'(errs), 32'd2);
         chk({tag, "/err_stall_cycles"}, 32'(waits), 32'd1);
      end else begin
         chk({tag, "/wait_cycles"}, 32'(waits), 32'(c_wait[d]));
         chk({tag, "/hresp"}, 32'(errs), 32'd0);
         if (wr) begin
            for (int k = 0; k < (1 << size); k++) begin
               a = addr + 32'(k);
               mdl[d][a[9:0]]   = wd[8*a[1:0] +: 8];
               known[d][a[9:0]] = 1'b1;
            end
         end else begin
            all_known = 1'b1;
            exp = 32'd0;
            for (int k = 0; k < 4; k++) begin
               a = {addr[31:2], 2'b00} + 32'(k);
               all_known &= known[d][a[9:0]];
               exp[8*k +: 8] = mdl[d][a[9:0]];
            end
            if (all_known) chk({tag, "/hrdata"}, rd, exp);
         end
      end
   endtask

   // Non-accepted address phase; the following cycle must be zero-wait OKAY.
   task automatic idle_cycle(input int d, input logic [1:0] tr, input bit sel, input string tag);
      hsel_v = 3'b000; hsel_v[d] = sel;
      htrans = tr; haddr = $urandom & 32'h3FC; hwrite = 1'($urandom); hready = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
      hsel_v = 3'b000; htrans = c_htrans_idle;
      chk({tag, "/hreadyout"}, {31'd0, w_ro[d]}, 32'd1);
      chk({tag, "/hresp"}, {31'd0, w_rs[d]}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] bdata [4];

      rstn = 3'b000; hsel_v = 3'b000; haddr = 32'd0; hwrite = 1'b0;
      hsize = 3'd2; hburst = 3'd0; htrans = c_htrans_idle; hready = 1'b1; hwdata = 32'd0;
      repeat (3) @(negedge hclk);
      for (int d = 0; d < 3; d++) begin
         chk("reset/hreadyout", {31'd0, w_ro[d]}, 32'd1);
         chk("reset/hresp", {31'd0, w_rs[d]}, 32'd0);
         chk("reset/hrdata", w_rd[d], 32'd0);
      end
      rstn = 3'b111;
      @(negedge hclk);

      // Word write then read, one wait state
      op(0, c_htrans_nonseq, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "w1_wr", rd);
      op(0, c_htrans_nonseq, 1'b0, 32'h10, 3'd2, 32'h0, "w1_rd", rd);
      chk("w1_rd_const", rd, 32'hDEADBEEF);

      // Byte writes into a zeroed word
      op(0, c_htrans_nonseq, 1'b1, 32'h20, 3'd2, 32'h0, "byte_pre", rd);
      op(0, c_htrans_nonseq, 1'b1, 32'h21, 3'd0, 32'h0000AA00, "byte_21", rd);
      op(0, c_htrans_nonseq, 1'b1, 32'h23, 3'd0, 32'h55000000, "byte_23", rd);
      op(0, c_htrans_nonseq, 1'b0, 32'h20, 3'd2, 32'h0, "byte_rd", rd);
      chk("byte_rd_const", rd, 32'h5500AA00);

      // Error paths leave word 0 untouched
      op(0, c_htrans_nonseq, 1'b1, 32'h00, 3'd2, 32'hA5A5A5A5, "err_pre", rd);
      op(0, c_htrans_nonseq, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, "err_range", rd);
      op(0, c_htrans_nonseq, 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, "err_misalign", rd);
      op(0, c_htrans_nonseq, 1'b0, 32'h00, 3'd2, 32'h0, "err_post_rd", rd);
      chk("err_post_const", rd, 32'hA5A5A5A5);

      // Zero-wait pipelined write then read of the same word (bypass)
      op(1, c_htrans_nonseq, 1'b1, 32'h30, 3'd2, 32'h12345678, "b2b_wr", rd);
      op(1, c_htrans_nonseq, 1'b0, 32'h30, 3'd2, 32'h0, "b2b_rd", rd);
      chk("b2b_rd_const", rd, 32'h12345678);
      op(1, c_htrans_nonseq, 1'b1, 32'h32, 3'd1, 32'hBEEF0000, "b2b_half", rd);
      op(1, c_htrans_nonseq, 1'b0, 32'h30, 3'd2, 32'h0, "b2b_merge", rd);
      chk("b2b_merge_const", rd, 32'hBEEF5678);

      // Reset during the second wait cycle of a three-wait write
      op(2, c_htrans_nonseq, 1'b1, 32'h40, 3'd2, 32'h0BADF00D, "rst_pre_wr", rd);
      op(2, c_htrans_nonseq, 1'b0, 32'h40, 3'd2, 32'h0, "rst_pre_rd", rd);
      hsel_v = 3'b100; htrans = c_htrans_nonseq; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk);
      @(negedge hclk);
      hsel_v = 3'b000; htrans = c_htrans_idle; hwdata = 32'hFFFFFFFF;
      chk("rst_wait1/hreadyout", {31'd0, w_ro[2]}, 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      chk("rst_wait2/hreadyout", {31'd0, w_ro[2]}, 32'd0);
      chk("rst_wait2/hrdata_held", w_rd[2], 32'h0BADF00D);
      rstn[2] = 1'b0;
      #1;
      chk("rst_async/hreadyout", {31'd0, w_ro[2]}, 32'd1);
      chk("rst_async/hresp", {31'd0, w_rs[2]}, 32'd0);
      chk("rst_async/hrdata", w_rd[2], 32'd0);
      @(negedge hclk);
      rstn[2] = 1'b1;
      @(negedge hclk);
      op(2, c_htrans_nonseq, 1'b0, 32'h40, 3'd2, 32'h0, "rst_post_rd", rd);
      chk("rst_post_const", rd, 32'h0BADF00D);

      // INCR4 burst interleaved with BUSY, unselected and IDLE cycles
      for (int i = 0; i < 4; i++) bdata[i] = $urandom;
      hburst = 3'd3;
      op(0, c_htrans_nonseq, 1'b1, 32'h200, 3'd2, bdata[0], "burst_b0", rd);
      idle_cycle(0, c_htrans_busy, 1'b1, "burst_busy");
      op(0, c_htrans_seq, 1'b1, 32'h204, 3'd2, bdata[1], "burst_b1", rd);
      idle_cycle(0, c_htrans_nonseq, 1'b0, "burst_unsel");
      op(0, c_htrans_seq, 1'b1, 32'h208, 3'd2, bdata[2], "burst_b2", rd);
      idle_cycle(0, c_htrans_idle, 1'b1, "burst_idle");
      op(0, c_htrans_seq, 1'b1, 32'h20C, 3'd2, bdata[3], "burst_b3", rd);
      hburst = 3'd0;
      for (int i = 0; i < 4; i++) begin
         op(0, c_htrans_nonseq, 1'b0, 32'h200 + 32'(4*i), 3'd2, 32'h0, "burst_rd", rd);
         chk("burst_rd_const", rd, bdata[i]);
      end

      // Randomized mixed traffic on every wait-state configuration
      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 16; w++)
            op(d, c_htrans_nonseq, 1'b1, 32'h300 + 32'(4*w), 3'd2, $urandom, "rnd_init", rd);
         for (int n = 0; n < 40; n++) begin
            size = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) size = 3'd3;
            addr = 32'h300 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 15) == 0) addr = 32'h400 + 32'($urandom_range(0, 255));
            op(d, c_htrans_nonseq, 1'($urandom), addr, size, $urandom, "rnd", rd);
            if ($urandom_range(0, 3) == 0) idle_cycle(d, c_htrans_idle, 1'b1, "rnd_idle");
         end
      end

      repeat (2) @(negedge hclk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
